duck_round_ctrl: RTL and testbench
==================================

Name: duck_round_ctrl

Overview:
- Parametrised game-round controller for N simultaneous ducks.
- Replaces the single-duck control/shot/score/bird keeper cluster with one block.
- Owns the round state machine, per-duck hit/fall/escape tracking, the shot budget, the saturating score, and the birds-remaining count.
- Sits between getCoordinates/cursor (shot, hit), the duck sprites and dog, and color_mapper/number_display (state, counters).

Parameters:
NUM_DUCKS, 2, ducks launched per round (1..4)
SHOTS_PER_ROUND, 3, shots allowed per round
BIRDS_PER_GAME, 10, total birds per game; must be a multiple of NUM_DUCKS
SCORE_PER_HIT, 500, points added per duck hit
SCORE_W, 32, score width
FLY_FRAMES, 300, frame ticks before unshot ducks flee
FLEE_FRAMES, 60, frame ticks spent in FLEE

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  asynchronous, active-high reset
start  in  1  level; start or restart a game
frame_clk  in  1  VGA_VS; asynchronous to game logic, synchronised internally
shot  in  1  one-cycle trigger pulse
hit  in  NUM_DUCKS  per-duck hit flags; sampled only in a cycle where shot=1
duck_ded_done  in  NUM_DUCKS  per-duck pulse: fall animation finished
dog_done  in  1  pulse: dog animation finished
state  out  3  IDLE=0 LAUNCH=1 FLYING=2 FALLING=3 FLEE=4 DOG=5 GAMEOVER=6
new_round  out  1  one-cycle pulse on entry to LAUNCH
duck_active  out  NUM_DUCKS  duck flying and shootable
duck_fall  out  NUM_DUCKS  duck hit and falling
flew_away  out  1  one-cycle pulse on entry to FLEE
dog_start  out  1  one-cycle pulse on entry to DOG
dog_duck  out  3  ducks hit this round (0..NUM_DUCKS)
shots_left  out  32  remaining shots, zero-extended
score  out  SCORE_W  game score
birds_left  out  32  birds remaining in game
game_over  out  1  high while in GAMEOVER

Behaviour:
- Reset values: state=IDLE; all pulses 0; duck_active=0; duck_fall=0; dog_duck=0; shots_left=SHOTS_PER_ROUND; score=0; birds_left=BIRDS_PER_GAME; game_over=0; frame timers 0.
- frame_clk synchronisation: two-flop synchroniser, then rising-edge detect, giving a one-cycle frame tick.
- IDLE: start=1 -> LAUNCH. Score and birds_left are reloaded on this transition.
- LAUNCH (exactly one cycle):
  - new_round=1.
  - duck_active set to all ones; duck_fall cleared; dog_duck cleared.
  - shots_left and fly timer reloaded.
  - Next state FLYING.
- FLYING:
  - shot with shots_left>0: shots_left decrements next cycle.
  - On that shot, m = hit & duck_active. For each set bit of m: clear active, set fall.
  - score += SCORE_PER_HIT*popcount(m), saturating at all-ones. dog_duck += popcount(m).
  - shot with shots_left=0: ignored entirely (no hit, no change).
  - Each frame tick increments the fly timer.
- FLYING exit priority, evaluated after the current shot is applied:
  - duck_active becomes 0 -> FALLING.
  - Otherwise shots_left becomes 0, or the fly timer reaches FLY_FRAMES -> FLEE.
  - A shot and timer expiry in the same cycle: the hit counts first.
- FALLING: a duck_ded_done bit clears the matching duck_fall bit. When duck_fall=0 -> DOG.
- FLEE:
  - Entry: flew_away=1 for one cycle; duck_active held. Falling ducks still complete via duck_ded_done.
  - After FLEE_FRAMES ticks and duck_fall=0: clear duck_active, go to DOG.
- DOG:
  - Entry: dog_start=1 for one cycle.
  - On dog_done: birds_left -= NUM_DUCKS, saturating at 0.
  - If the result is 0 -> GAMEOVER, else -> LAUNCH.
- GAMEOVER: game_over=1; score and counters held. start=1 -> reload score and birds_left -> LAUNCH.
- Ignored inputs:
  - shot and hit outside FLYING.
  - start outside IDLE/GAMEOVER.
  - duck_ded_done for a bit that is not falling.
  - dog_done outside DOG.
- Reset mid-operation: immediate return to reset values. No pulse is emitted during or on release of reset.

Test Plan:
- Reset, start, N=2: LAUNCH pulse, duck_active=2'b11, shots_left=3. Shot with hit=2'b01 -> score=500, duck_fall=01, shots_left=2. Shot with hit=2'b10 -> score=1000, state=FALLING. Both ded_done -> DOG with dog_start, dog_duck=2. dog_done -> birds_left=8, LAUNCH.
- Three shots, all hit=0 -> shots_left=0, FLEE with flew_away pulse. 60 ticks -> DOG, dog_duck=0, score unchanged. A 4th shot is ignored.
- No shots, 300 frame ticks -> FLEE. Shot with hit=2'b11 coincident with the 300th tick -> score=+1000, state=FALLING, no flew_away.
- Five full rounds -> birds_left=0, GAMEOVER, game_over=1. Start -> score=0, birds_left=10, LAUNCH.
- score preset near max (SCORE_W=12), hit both -> score saturates at 4095. Shot with hit=2'b11 while duck_active=2'b01 -> score +500 only.
- Reset asserted mid-FALLING -> state=IDLE, duck_fall=0, score=0 immediately, asynchronously with no clock edge.

Source files
------------

// File: rtl/duck_round_ctrl.sv
// Round controller for NUM_DUCKS simultaneous ducks: round FSM, per-duck hit/fall
// tracking, shot budget, saturating score and birds-remaining count.
module duck_round_ctrl #(
  parameter int unsigned NUM_DUCKS       = 2,
  parameter int unsigned SHOTS_PER_ROUND = 3,
  parameter int unsigned BIRDS_PER_GAME  = 10,
  parameter int unsigned SCORE_PER_HIT   = 500,
  parameter int unsigned SCORE_W         = 32,
  parameter int unsigned FLY_FRAMES      = 300,
  parameter int unsigned FLEE_FRAMES     = 60
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 frame_clk,
  input  logic                 shot,
  input  logic [NUM_DUCKS-1:0] hit,
  input  logic [NUM_DUCKS-1:0] duck_ded_done,
  input  logic                 dog_done,
  output logic [2:0]           state,
  output logic                 new_round,
  output logic [NUM_DUCKS-1:0] duck_active,
  output logic [NUM_DUCKS-1:0] duck_fall,
  output logic                 flew_away,
  output logic                 dog_start,
  output logic [2:0]           dog_duck,
  output logic [31:0]          shots_left,
  output logic [SCORE_W-1:0]   score,
  output logic [31:0]          birds_left,
  output logic                 game_over
);

  localparam int unsigned FLY_W  = $clog2(FLY_FRAMES + 1);
  localparam int unsigned FLEE_W = $clog2(FLEE_FRAMES + 1);
  localparam logic [63:0] SCORE_MAX = (64'd1 << SCORE_W) - 64'd1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LAUNCH   = 3'd1,
    S_FLYING   = 3'd2,
    S_FALLING  = 3'd3,
    S_FLEE     = 3'd4,
    S_DOG      = 3'd5,
    S_GAMEOVER = 3'd6
  } state_e;

  state_e               state_q;
  logic [2:0]           sync_q;
  logic                 new_round_q, flew_q, dog_start_q, game_over_q;
  logic [NUM_DUCKS-1:0] active_q, fall_q;
  logic [2:0]           dog_duck_q;
  logic [31:0]          shots_q, birds_q;
  logic [SCORE_W-1:0]   score_q;
  logic [FLY_W-1:0]     fly_q;
  logic [FLEE_W-1:0]    flee_q;

  logic                 tick_c, shot_ok_c, launch_c;
  logic [NUM_DUCKS-1:0] hit_m_c, active_d, fall_d;
  logic [2:0]           hit_n_c;
  logic [31:0]          shots_d, birds_d;
  logic [63:0]          add_c, sum_c;
  logic [SCORE_W-1:0]   score_d;
  logic [FLY_W-1:0]     fly_d;
  logic [FLEE_W-1:0]    flee_d;

  function automatic logic [2:0] popcnt(input logic [NUM_DUCKS-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < NUM_DUCKS; i++) c = c + 3'(v[i]);
    return c;
  endfunction

  // Candidate next values; the FSM picks which ones apply in each state.
  always_comb begin
    tick_c    = sync_q[1] & ~sync_q[2];
    shot_ok_c = (state_q == S_FLYING) && shot && (shots_q != 32'd0);
    hit_m_c   = shot_ok_c ? (hit & active_q) : '0;
    hit_n_c   = popcnt(hit_m_c);
    active_d  = active_q & ~hit_m_c;
    fall_d    = (fall_q & ~duck_ded_done) | hit_m_c;
    shots_d   = shot_ok_c ? shots_q - 32'd1 : shots_q;
    add_c     = 64'(SCORE_PER_HIT) * 64'(hit_n_c);
    sum_c     = 64'(score_q) + add_c;
    score_d   = (sum_c > SCORE_MAX) ? '1 : SCORE_W'(sum_c);
    fly_d     = tick_c ? fly_q + FLY_W'(1) : fly_q;
    flee_d    = (tick_c && (flee_q < FLEE_W'(FLEE_FRAMES))) ? flee_q + FLEE_W'(1) : flee_q;
    birds_d   = (birds_q > 32'(NUM_DUCKS)) ? birds_q - 32'(NUM_DUCKS) : 32'd0;
    launch_c  = (((state_q == S_IDLE) || (state_q == S_GAMEOVER)) && start) ||
                ((state_q == S_DOG) && dog_done && (birds_d != 32'd0));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      new_round_q <= 1'b0;
      flew_q      <= 1'b0;
      dog_start_q <= 1'b0;
      game_over_q <= 1'b0;
      active_q    <= '0;
      fall_q      <= '0;
      dog_duck_q  <= '0;
      shots_q     <= 32'(SHOTS_PER_ROUND);
      score_q     <= '0;
      birds_q     <= 32'(BIRDS_PER_GAME);
      fly_q       <= '0;
      flee_q      <= '0;
    end else begin
      sync_q      <= {sync_q[1:0], frame_clk};
      new_round_q <= 1'b0;
      flew_q      <= 1'b0;
      dog_start_q <= 1'b0;
      case (state_q)
        S_IDLE, S_GAMEOVER: begin
          if (start) begin
            score_q     <= '0;
            birds_q     <= 32'(BIRDS_PER_GAME);
            game_over_q <= 1'b0;
          end
        end
        S_LAUNCH: state_q <= S_FLYING;
        S_FLYING: begin
          active_q   <= active_d;
          fall_q     <= fall_d;
          shots_q    <= shots_d;
          score_q    <= score_d;
          dog_duck_q <= dog_duck_q + hit_n_c;
          fly_q      <= fly_d;
          // Hits are applied before the flee decision, so a final kill beats timeout.
          if (active_d == '0) begin
            state_q <= S_FALLING;
          end else if ((shots_d == 32'd0) || (fly_d == FLY_W'(FLY_FRAMES))) begin
            state_q <= S_FLEE;
            flew_q  <= 1'b1;
            flee_q  <= '0;
          end
        end
        S_FALLING: begin
          fall_q <= fall_d;
          if (fall_d == '0) begin
            state_q     <= S_DOG;
            dog_start_q <= 1'b1;
          end
        end
        S_FLEE: begin
          fall_q <= fall_d;
          flee_q <= flee_d;
          if ((flee_d >= FLEE_W'(FLEE_FRAMES)) && (fall_d == '0)) begin
            active_q    <= '0;
            state_q     <= S_DOG;
            dog_start_q <= 1'b1;
          end
        end
        S_DOG: begin
          if (dog_done) begin
            birds_q <= birds_d;
            if (birds_d == 32'd0) begin
              state_q     <= S_GAMEOVER;
              game_over_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Round setup is applied on entry so LAUNCH already shows the fresh round.
      if (launch_c) begin
        state_q     <= S_LAUNCH;
        new_round_q <= 1'b1;
        active_q    <= '1;
        fall_q      <= '0;
        dog_duck_q  <= '0;
        shots_q     <= 32'(SHOTS_PER_ROUND);
        fly_q       <= '0;
      end
    end
  end

  assign state       = state_q;
  assign new_round   = new_round_q;
  assign duck_active = active_q;
  assign duck_fall   = fall_q;
  assign flew_away   = flew_q;
  assign dog_start   = dog_start_q;
  assign dog_duck    = dog_duck_q;
  assign shots_left  = shots_q;
  assign score       = score_q;
  assign birds_left  = birds_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Directed bench for duck_round_ctrl (N=2, SCORE_W=12): hits, misses, timeout,
// coincident shot/timeout, game over, score saturation and async reset.
module tb_duck_round_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, start, frame_clk, shot, dog_done;
  logic [1:0]  hit, duck_ded_done;
  logic [2:0]  state;
  logic        new_round, flew_away, dog_start, game_over;
  logic [1:0]  duck_active, duck_fall;
  logic [2:0]  dog_duck;
  logic [31:0] shots_left, birds_left;
  logic [11:0] score;

  int checks   = 0;
  int failures = 0;

  duck_round_ctrl #(.NUM_DUCKS(2), .SHOTS_PER_ROUND(3), .BIRDS_PER_GAME(10),
                    .SCORE_PER_HIT(500), .SCORE_W(12), .FLY_FRAMES(300), .FLEE_FRAMES(60)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .frame_clk(frame_clk), .shot(shot),
    .hit(hit), .duck_ded_done(duck_ded_done), .dog_done(dog_done), .state(state),
    .new_round(new_round), .duck_active(duck_active), .duck_fall(duck_fall),
    .flew_away(flew_away), .dog_start(dog_start), .dog_duck(dog_duck),
    .shots_left(shots_left), .score(score), .birds_left(birds_left), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic shoot(input logic [1:0] h);
    shot = 1'b1; hit = h;
    step();
    shot = 1'b0; hit = 2'b00;
  endtask

  // One frame tick; returns right after the FSM has consumed it.
  task automatic tick();
    frame_clk = 1'b0;
    repeat (3) step();
    frame_clk = 1'b1;
    repeat (3) step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ded(input logic [1:0] d);
    duck_ded_done = d;
    step();
    duck_ded_done = 2'b00;
  endtask

  task automatic dog();
    dog_done = 1'b1;
    step();
    dog_done = 1'b0;
  endtask

  task automatic hit_round(input logic [63:0] exp_score, input logic [63:0] exp_birds);
    shoot(2'b11);
    check("hr_score", score, exp_score);
    check("hr_fall_state", state, 3);
    ded(2'b11);
    check("hr_dog_state", state, 5);
    dog();
    check("hr_birds", birds_left, exp_birds);
    check("hr_launch", state, 1);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; start = 1'b0; frame_clk = 1'b0; shot = 1'b0; dog_done = 1'b0;
    hit = 2'b00; duck_ded_done = 2'b00;
    #1;
    check("rst_state", state, 0);
    check("rst_shots", shots_left, 3);
    check("rst_birds", birds_left, 10);
    check("rst_score", score, 0);
    check("rst_active", duck_active, 0);
    check("rst_pulses", {new_round, flew_away, dog_start, game_over}, 0);
    step(); step();
    Reset = 1'b0;
    step();
    check("rel_state", state, 0);
    check("rel_new_round", new_round, 0);

    // Round 1: two hits, both fall, dog
    start = 1'b1; step(); start = 1'b0;
    check("r1_launch", state, 1);
    check("r1_new_round", new_round, 1);
    check("r1_active", duck_active, 2'b11);
    check("r1_shots", shots_left, 3);
    step();
    check("r1_flying", state, 2);
    check("r1_nr_clear", new_round, 0);
    shoot(2'b01);
    check("r1_s1_score", score, 500);
    check("r1_s1_fall", duck_fall, 2'b01);
    check("r1_s1_active", duck_active, 2'b10);
    check("r1_s1_shots", shots_left, 2);
    shoot(2'b10);
    check("r1_s2_score", score, 1000);
    check("r1_s2_state", state, 3);
    check("r1_s2_dogduck", dog_duck, 2);
    ded(2'b11);
    check("r1_dog_state", state, 5);
    check("r1_dog_start", dog_start, 1);
    check("r1_fall_clear", duck_fall, 0);
    step();
    check("r1_dog_start_clr", dog_start, 0);
    dog();
    check("r1_birds", birds_left, 8);
    check("r1_relaunch", state, 1);
    step();

    // Round 2: three misses -> FLEE, fourth shot ignored
    shoot(2'b00); shoot(2'b00); shoot(2'b00);
    check("r2_shots", shots_left, 0);
    check("r2_flee", state, 4);
    check("r2_flew_away", flew_away, 1);
    check("r2_active_held", duck_active, 2'b11);
    step();
    check("r2_flew_clr", flew_away, 0);
    shoot(2'b11);
    check("r2_4th_score", score, 1000);
    check("r2_4th_active", duck_active, 2'b11);
    ticks(59);
    check("r2_flee_59", state, 4);
    tick();
    check("r2_dog", state, 5);
    check("r2_dog_start", dog_start, 1);
    check("r2_dog_duck", dog_duck, 0);
    check("r2_active_clr", duck_active, 0);
    check("r2_score", score, 1000);
    dog();
    check("r2_birds", birds_left, 6);
    step();

    // Round 3: no shots, fly timer expires
    ticks(299);
    check("r3_fly_299", state, 2);
    tick();
    check("r3_flee", state, 4);
    check("r3_flew_away", flew_away, 1);
    ticks(60);
    check("r3_dog", state, 5);
    dog();
    check("r3_birds", birds_left, 4);
    step();

    // Round 4: double hit coincides with the 300th tick
    ticks(299);
    check("r4_fly_299", state, 2);
    frame_clk = 1'b0; repeat (3) step();
    frame_clk = 1'b1; step(); step();
    shoot(2'b11);
    check("r4_score", score, 2000);
    check("r4_falling", state, 3);
    check("r4_no_flew", flew_away, 0);
    check("r4_shots", shots_left, 2);
    ded(2'b01);
    check("r4_fall_partial", duck_fall, 2'b10);
    check("r4_still_falling", state, 3);
    ded(2'b10);
    check("r4_dog", state, 5);
    dog();
    check("r4_birds", birds_left, 2);
    step();

    // Round 5: hit on an already-fallen duck scores only once
    shoot(2'b01);
    check("r5_s1_score", score, 2500);
    shoot(2'b11);
    check("r5_s2_score", score, 3000);
    check("r5_s2_state", state, 3);
    check("r5_dog_duck", dog_duck, 2);
    ded(2'b11);
    dog();
    check("go_state", state, 6);
    check("go_flag", game_over, 1);
    check("go_birds", birds_left, 0);
    check("go_new_round", new_round, 0);
    shoot(2'b11);
    step(); step();
    check("go_score_held", score, 3000);
    check("go_held", state, 6);
    start = 1'b1; step(); start = 1'b0;
    check("g2_launch", state, 1);
    check("g2_score", score, 0);
    check("g2_birds", birds_left, 10);
    check("g2_go_clr", game_over, 0);
    check("g2_new_round", new_round, 1);
    step();

    // Game 2: start ignored mid-round, then drive score into saturation
    start = 1'b1; step(); start = 1'b0;
    check("g2_start_ignored", state, 2);
    hit_round(1000, 8);
    hit_round(2000, 6);
    hit_round(3000, 4);
    hit_round(4000, 2);
    shoot(2'b11);
    check("sat_score", score, 4095);
    check("sat_state", state, 3);

    // Asynchronous reset mid-FALLING
    #2;
    Reset = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_fall", duck_fall, 0);
    check("arst_score", score, 0);
    check("arst_birds", birds_left, 10);
    step();
    Reset = 1'b0;
    step();
    check("arst_rel_state", state, 0);
    check("arst_rel_pulses", {new_round, flew_away, dog_start}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
